board_mem_arbiter: RTL and testbench

Shares port B of the board-state dual-port RAM (`dmem_valid`) between the PS2 keyboard write path and the VGA renderer read path. It replaces gating the VGA clock during keyboard writes. Keyboard writes are queued in a small FIFO, and VGA reads are arbitrated with bounded write starvation. Read data is returned with a fixed, parametrised RAM latency, so the VGA pixel pipeline never loses its clock.

---
 rtl/board_mem_arbiter.sv | 115 +++++++++++
 tb/tb_board_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
// Shares board-state RAM port B between the queued keyboard write path and the
// VGA read path: reads win until a write has waited STARVE_MAX grants.
module board_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int WQ_DEPTH   = 4,
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic                        wr_valid,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_ready,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_q,
    output logic [$clog2(WQ_DEPTH):0]   wq_count,
    output logic                        wq_overflow
);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(WQ_DEPTH);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

    logic [ADDR_W-1:0]     fifoAddr_q [WQ_DEPTH];
    logic [DATA_W-1:0]     fifoData_q [WQ_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic [RD_LATENCY-1:0] rdPipe_q, rdPipe_d;
    logic                  overflow_q, overflow_d;

    logic empty, full, forceW, wSlot, rGrant, push;

    // A forced write blocks reads for exactly one cycle; otherwise reads always win.
    always_comb begin
        empty  = (count_q == '0);
        full   = (count_q == FULL_CNT);
        forceW = !empty && (starve_q == STARVE_LIM);
        wSlot  = resetn && !empty && (!rd_req || forceW);
        rGrant = resetn && rd_req && !forceW;
        push   = resetn && wr_valid && !full;
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        starve_d   = starve_q;
        overflow_d = overflow_q | (wr_valid && full);
        rdPipe_d   = rdPipe_q << 1;
        rdPipe_d[0] = rGrant;

        if (push)  tail_d = tail_q + PTR_W'(1);
        if (wSlot) head_d = head_q + PTR_W'(1);

        case ({push, wSlot})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The starve count only measures reads that overtook a waiting write.
        if (wSlot || empty)
            starve_d = '0;
        else if (rGrant && (starve_q != STARVE_LIM))
            starve_d = starve_q + STV_W'(1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rdPipe_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rdPipe_q   <= rdPipe_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifoAddr_q[tail_q] <= wr_addr;
            fifoData_q[tail_q] <= wr_data;
        end
    end

    assign wr_ready    = resetn && !full;
    assign rd_ready    = resetn && !forceW;
    assign mem_wren    = wSlot;
    assign mem_addr    = wSlot ? fifoAddr_q[head_q] : rd_addr;
    assign mem_data    = wSlot ? fifoData_q[head_q] : '0;
    assign rd_valid    = resetn && rdPipe_q[RD_LATENCY-1];
    assign rd_data     = rd_valid ? mem_q : '0;
    assign wq_count    = count_q;
    assign wq_overflow = overflow_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Scoreboard bench for board_mem_arbiter: a queue-based reference model predicts
// arbitration and read/write results; a negedge monitor checks what the DUT presents.
module tb_board_mem_arbiter;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int WQ_DEPTH   = 4;
    localparam int RD_LATENCY = 2;
    localparam int STARVE_MAX = 8;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic [$clog2(WQ_DEPTH):0] wq_count;
    logic              wq_overflow;

    board_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WQ_DEPTH(WQ_DEPTH),
        .RD_LATENCY(RD_LATENCY), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLOCK_50(clock), .resetn(resetn),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
        .wq_count(wq_count), .wq_overflow(wq_overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int passCnt = 0;
    int checkCnt = 0;

    function automatic logic [31:0] initVal(input logic [ADDR_W-1:0] a);
        if (a == 12'd8) return 32'h0000_00A5;
        return {20'hC0DE0, a} ^ 32'h5A00_0000;
    endfunction

    // Behavioural RAM for port B with an RD_LATENCY-deep read pipeline.
    bit [DATA_W-1:0] ramData [4096];
    bit              ramWritten [4096];
    bit [DATA_W-1:0] ramPipe [RD_LATENCY];

    always @(posedge clock) begin
        if (mem_wren) begin
            ramData[mem_addr]    <= mem_data;
            ramWritten[mem_addr] <= 1'b1;
        end
        ramPipe[0] <= ramWritten[mem_addr] ? ramData[mem_addr] : initVal(mem_addr);
        for (int i = 1; i < RD_LATENCY; i++) ramPipe[i] <= ramPipe[i-1];
    end
    assign mem_q = ramPipe[RD_LATENCY-1];

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
    typedef struct { logic [DATA_W-1:0] data; int due; } rd_t;

    wr_t modelQ[$];
    wr_t expWr[$];
    rd_t expRd[$];
    logic [DATA_W-1:0] modelMem [int];
    int starve = 0;
    bit ovf = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: predicts this cycle's arbitration and advances to the next edge.
    task automatic stepModel();
        int n;
        bit forceW, wslot, rdy, rgrant;
        wr_t w;
        rd_t r;
        if (!resetn) begin
            checkOutput("rst_rd_ready", rd_ready, 0);
            checkOutput("rst_wr_ready", wr_ready, 0);
            checkOutput("rst_mem_wren", mem_wren, 0);
            checkOutput("rst_rd_valid", rd_valid, 0);
            modelQ.delete();
            expWr.delete();
            expRd.delete();
            starve = 0;
            ovf = 1'b0;
        end else begin
            n      = modelQ.size();
            forceW = (n > 0) && (starve == STARVE_MAX);
            wslot  = (n > 0) && (!rd_req || forceW);
            rdy    = !forceW;
            rgrant = rd_req && rdy;
            checkOutput("rd_ready", rd_ready, rdy);
            checkOutput("wr_ready", wr_ready, n < WQ_DEPTH);
            checkOutput("mem_wren", mem_wren, wslot);
            checkOutput("wq_count", wq_count, n);
            checkOutput("wq_overflow", wq_overflow, ovf);
            if (rgrant) begin
                r.data = modelMem.exists(int'(rd_addr)) ? modelMem[int'(rd_addr)] : initVal(rd_addr);
                r.due  = cyc + RD_LATENCY;
                expRd.push_back(r);
            end
            if (wslot) begin
                w = modelQ.pop_front();
                modelMem[int'(w.addr)] = w.data;
            end
            if (wr_valid) begin
                if (n < WQ_DEPTH) begin
                    w.addr = wr_addr;
                    w.data = wr_data;
                    modelQ.push_back(w);
                    expWr.push_back(w);
                end else begin
                    ovf = 1'b1;
                end
            end
            if (wslot || n == 0) starve = 0;
            else if (rgrant && starve < STARVE_MAX) starve++;
        end
    endtask

    task automatic applyStimulus(input bit rstN, input bit rq, input logic [ADDR_W-1:0] ra,
                                 input bit wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        @(posedge clock);
        #1;
        resetn   = rstN;
        rd_req   = rq;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        #3;
        stepModel();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic randomCycles(input int n);
        repeat (n) applyStimulus(1'b1, $urandom_range(0, 9) < 7, ADDR_W'($urandom_range(0, 15)),
                                 $urandom_range(0, 9) < 4, ADDR_W'($urandom_range(0, 15)), $urandom);
    endtask

    // Monitor: compares read returns and RAM writes against the scoreboard queues.
    initial begin
        rd_t r;
        wr_t w;
        forever begin
            @(negedge clock);
            if (rd_valid) begin
                if (expRd.size() == 0) checkOutput("rd_valid_unexpected", rd_valid, 0);
                else begin
                    r = expRd.pop_front();
                    checkOutput("rd_cycle", cyc, r.due);
                    checkOutput("rd_data", rd_data, r.data);
                end
            end else begin
                if (expRd.size() > 0 && expRd[0].due <= cyc) begin
                    r = expRd.pop_front();
                    checkOutput("rd_valid_missing", rd_valid, 1);
                end
                checkOutput("rd_data_idle", rd_data, 0);
            end
            if (mem_wren) begin
                if (expWr.size() == 0) checkOutput("mem_wren_unexpected", mem_wren, 0);
                else begin
                    w = expWr.pop_front();
                    checkOutput("ram_wr_addr", mem_addr, w.addr);
                    checkOutput("ram_wr_data", mem_data, w.data);
                end
            end else begin
                checkOutput("mem_addr_rd", mem_addr, rd_addr);
                checkOutput("mem_data_idle", mem_data, 0);
            end
        end
    end

    initial begin
        repeat (3) applyStimulus(1'b0, 1'b1, 12'd5, 1'b1, 12'd7, 32'h1234);
        idle(1);

        applyStimulus(1'b1, 1'b0, '0, 1'b1, 12'd36, 32'h49);
        idle(2);

        applyStimulus(1'b1, 1'b1, 12'd8, 1'b0, '0, '0);
        idle(3);

        applyStimulus(1'b1, 1'b1, ADDR_W'($urandom_range(0, 15)), 1'b1, 12'd100, $urandom);
        repeat (12) applyStimulus(1'b1, 1'b1, ADDR_W'($urandom_range(0, 15)), 1'b0, '0, '0);
        idle(4);

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, ADDR_W'($urandom_range(0, 15)), 1'b1, ADDR_W'(200 + i), $urandom);
        repeat (40) applyStimulus(1'b1, 1'b1, ADDR_W'($urandom_range(200, 204)), 1'b0, '0, '0);
        idle(3);

        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b0, '0, 1'b1, ADDR_W'(300 + i), $urandom);
        idle(3);

        randomCycles(300);
        repeat (2) applyStimulus(1'b0, 1'b1, 12'd3, 1'b1, 12'd4, $urandom);
        randomCycles(100);
        idle(10);

        checkOutput("rd_scoreboard_drained", expRd.size(), 0);
        checkOutput("wr_scoreboard_drained", expWr.size(), 0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
